// File: rtl/mmio_bridge_if.sv
// CPU data-port and dmem bus bundle for mmio_bridge.
// slave: the bridge itself; master: processor core plus data memory.
interface mmio_bridge_if;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wren;
  logic        cpu_rden;
  logic [31:0] cpu_rdata;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_data;
  logic        dmem_wren;
  logic [31:0] dmem_q;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wren, cpu_rden, dmem_q,
    output cpu_rdata, dmem_addr, dmem_data, dmem_wren
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wren, cpu_rden, dmem_q,
    input  cpu_rdata, dmem_addr, dmem_data, dmem_wren
  );
endinterface

// File: rtl/mmio_bridge.sv
// Data-port address decoder: dmem pass-through below MMIO_BASE, I/O registers
// (scancode FIFO, LED, cycle counter) above. Define KEY_BREAK_FILTER_EN to drop PS/2 break sequences.
module mmio_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [11:0] MMIO_BASE  = 12'hFF0
) (
  input  logic              clock,
  input  logic              reset,
  mmio_bridge_if.slave      bus,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic              key_ready,
  output logic [15:0]       led
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_DATA   = 2'd1;
  localparam logic [1:0] OFF_LED    = 2'd2;
  localparam logic [1:0] OFF_CYCLE  = 2'd3;

  logic [12:0]   addr_ext;
  logic [12:0]   base_ext;
  logic          is_io;
  logic [1:0]    off;
  logic [11:0]   off_full;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycle;

  logic          full;
  logic          empty;
  logic          push_cand;
  logic          pop;
  logic          do_push;
  logic          ovf_set;
  logic          wr_status;
  logic          wr_led;
  logic          wr_cycle;
  logic [31:0]   io_rdata;

  // Widen by one bit so MMIO_BASE+3 cannot wrap at the top of the address space
  assign addr_ext = {1'b0, bus.cpu_addr};
  assign base_ext = {1'b0, MMIO_BASE};
  assign is_io    = (addr_ext >= base_ext) && (addr_ext <= base_ext + 13'd3);
  assign off_full = bus.cpu_addr - MMIO_BASE;
  assign off      = off_full[1:0];

  assign bus.dmem_addr = bus.cpu_addr;
  assign bus.dmem_data = bus.cpu_wdata;
  assign bus.dmem_wren = bus.cpu_wren & ~is_io & reset;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == CW'(0));
  assign key_ready = ~full;

  assign wr_status = bus.cpu_wren & is_io & (off == OFF_STATUS);
  assign wr_led    = bus.cpu_wren & is_io & (off == OFF_LED);
  assign wr_cycle  = bus.cpu_wren & is_io & (off == OFF_CYCLE);

`ifdef KEY_BREAK_FILTER_EN
  typedef enum logic {FLT_IDLE, FLT_BREAK} flt_state_t;
  flt_state_t flt_state;

  // F0 arms BREAK; the byte following it is swallowed
  always_ff @(posedge clock) begin
    if (!reset) begin
      flt_state <= FLT_IDLE;
    end else if (key_valid) begin
      case (flt_state)
        FLT_IDLE:  flt_state <= (key_code == 8'hF0) ? FLT_BREAK : FLT_IDLE;
        FLT_BREAK: flt_state <= FLT_IDLE;
        default:   flt_state <= FLT_IDLE;
      endcase
    end
  end

  assign push_cand = key_valid && (flt_state == FLT_IDLE) && (key_code != 8'hF0);
`else
  assign push_cand = key_valid;
`endif

  // A pop frees the slot a same-cycle push needs, so full+pop+push is lossless
  assign pop     = bus.cpu_rden & is_io & (off == OFF_DATA) & ~empty;
  assign do_push = push_cand & (~full | pop);
  assign ovf_set = push_cand & full & ~pop;

  always_comb begin
    io_rdata = 32'd0;
    case (off)
      OFF_STATUS: io_rdata = {overflow, 25'd0, 5'(count), ~empty};
      OFF_DATA:   io_rdata = empty ? 32'd0 : {24'd0, mem[rd_ptr]};
      OFF_LED:    io_rdata = {16'd0, led};
      OFF_CYCLE:  io_rdata = cycle;
      default:    io_rdata = 32'd0;
    endcase
  end

  assign bus.cpu_rdata = is_io ? (bus.cpu_rden ? io_rdata : 32'd0) : bus.dmem_q;

  // Storage needs no reset: count/pointers define what is valid
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (pop && !do_push) count <= count - CW'(1);
    end
  end

  // Set has priority over a same-cycle software clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (wr_status && bus.cpu_wdata[31]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      led <= 16'd0;
    end else if (wr_led) begin
      led <= bus.cpu_wdata[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle <= 32'd0;
    end else if (wr_cycle) begin
      cycle <= 32'd0;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

endmodule
